// File: rtl/pad_stream_if.sv
// Character stream bundle for pad_stream: input handshake and output handshake.
// Latency: none, wires only.
// Backpressure: in_ready throttles the producer, out_ready throttles the consumer.
//
// Signals
//   in_valid / in_ready / cin              : input characters, accepted on in_valid && in_ready
//   out_valid / out_ready / cout / out_last: output characters, beat accepted on out_valid && out_ready
//
// Modports
//   slave  : the pad_stream block (consumes input stream, produces output stream)
//   master : the environment (produces input stream, consumes output stream)
interface pad_stream_if #(
  parameter int CHAR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] cin;
  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W-1:0] cout;
  logic              out_last;

  modport slave (
    input  in_valid,
    input  cin,
    output in_ready,
    output out_valid,
    input  out_ready,
    output cout,
    output out_last
  );

  modport master (
    output in_valid,
    output cin,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  cout,
    input  out_last
  );
endinterface

// File: rtl/pad_stream.sv
// Buffers a string of up to STR_LEN_MAX characters, then emits it padded to a desired length.
// Latency: strlen input beats, then max(strlen, desired) output beats; done one cycle after the last beat.
// Backpressure: in_ready only while reading; output holds cout/out_valid/out_last while out_ready is low.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : begin a job (sampled only when idle)
//   strlen_i          : input string length (clamped to STR_LEN_MAX), latched on start
//   desired_i         : desired output length, latched on start
//   cpad_i            : pad character, latched on start
//   mode_i            : 0 = pad on the left, 1 = pad on the right, latched on start
//   st                : pad_stream_if slave (input and output character streams)
//   busy_o            : high whenever a job is in progress
//   done_o            : one-cycle pulse after a job completes normally
//
// Build option
//   PAD_STREAM_TRUNC_EN : when defined, a desired length shorter than the string truncates
//                         the string to its first desired characters (no pad emitted).
module pad_stream #(
  parameter int STR_LEN_MAX = 8,
  parameter int CHAR_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [$clog2(STR_LEN_MAX+1)-1:0]     strlen_i,
  input  logic [$clog2(2*STR_LEN_MAX+1)-1:0]   desired_i,
  input  logic [CHAR_W-1:0]                    cpad_i,
  input  logic                                 mode_i,
  pad_stream_if.slave                          st,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int LW = $clog2(STR_LEN_MAX+1);
  localparam int DW = $clog2(2*STR_LEN_MAX+1);
  localparam int AW = (STR_LEN_MAX > 1) ? $clog2(STR_LEN_MAX) : 1;

  localparam logic [LW-1:0] MAX_L = LW'(STR_LEN_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    PAD  = 2'd2,
    STR  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and job registers
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [DW-1:0]     idx_q,   idx_d;    // write index in READ, beat index within PAD/STR
  logic [DW-1:0]     len_q,   len_d;    // characters to read
  logic [DW-1:0]     sout_q,  sout_d;   // string characters to emit
  logic [DW-1:0]     pad_q,   pad_d;    // pad characters to emit
  logic [CHAR_W-1:0] cpad_q,  cpad_d;
  logic              mode_q,  mode_d;
  logic              done_q,  done_d;

  logic [CHAR_W-1:0] mem_q [STR_LEN_MAX];

  // ---------------------------------------------------------------------------
  // Job parameters derived from the start inputs
  // ---------------------------------------------------------------------------
  logic [LW-1:0] slen_clamp;
  logic [DW-1:0] slen_w;
  logic [DW-1:0] pad_new;
  logic [DW-1:0] sout_new;

  always_comb begin
    slen_clamp = (strlen_i > MAX_L) ? MAX_L : strlen_i;
    slen_w     = DW'(slen_clamp);
    // Compare before subtracting so a short desired length never wraps.
    pad_new    = (desired_i > slen_w) ? (desired_i - slen_w) : '0;
`ifdef PAD_STREAM_TRUNC_EN
    sout_new   = (desired_i < slen_w) ? desired_i : slen_w;
`else
    sout_new   = slen_w;
`endif
  end

  // First output phase for a job; IDLE means the job has nothing to emit.
  // An empty phase is skipped here so no idle cycle appears between phases.
  function automatic state_t first_phase(input logic md,
                                         input logic [DW-1:0] pl,
                                         input logic [DW-1:0] sl);
    state_t ph;
    ph = IDLE;
    if (!md) begin
      if (pl != '0)      ph = PAD;
      else if (sl != '0) ph = STR;
    end else begin
      if (sl != '0)      ph = STR;
      else if (pl != '0) ph = PAD;
    end
    return ph;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic              in_ready_c;
  logic              out_valid_c;
  logic [CHAR_W-1:0] cout_c;
  logic              last_c;
  logic              pad_end;
  logic              str_end;
  state_t            nxt;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    sout_d      = sout_q;
    pad_d       = pad_q;
    cpad_d      = cpad_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    cout_c      = '0;
    last_c      = 1'b0;
    nxt         = IDLE;
    pad_end     = (idx_q == (pad_q  - DW'(1)));
    str_end     = (idx_q == (sout_q - DW'(1)));

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d  = slen_w;
          sout_d = sout_new;
          pad_d  = pad_new;
          cpad_d = cpad_i;
          mode_d = mode_i;
          idx_d  = '0;
          if (slen_w != '0) begin
            state_d = READ;
          end else begin
            nxt     = first_phase(mode_i, pad_new, sout_new);
            state_d = nxt;
            done_d  = (nxt == IDLE);
          end
        end
      end

      READ: begin
        in_ready_c = 1'b1;
        if (st.in_valid) begin
          if (idx_q == (len_q - DW'(1))) begin
            idx_d   = '0;
            nxt     = first_phase(mode_q, pad_q, sout_q);
            state_d = nxt;
            // Truncation to zero characters leaves nothing to emit.
            done_d  = (nxt == IDLE);
          end else begin
            idx_d = idx_q + DW'(1);
          end
        end
      end

      PAD: begin
        out_valid_c = 1'b1;
        cout_c      = cpad_q;
        // Pad is the last phase when it trails the string or there is no string.
        last_c      = pad_end && (mode_q || (sout_q == '0));
        if (st.out_ready) begin
          if (pad_end) begin
            idx_d = '0;
            if (!mode_q && (sout_q != '0)) begin
              state_d = STR;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + DW'(1);
          end
        end
      end

      STR: begin
        out_valid_c = 1'b1;
        cout_c      = mem_q[idx_q[AW-1:0]];
        last_c      = str_end && (!mode_q || (pad_q == '0));
        if (st.out_ready) begin
          if (str_end) begin
            idx_d = '0;
            if (mode_q && (pad_q != '0)) begin
              state_d = PAD;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + DW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset masks the handshakes in the same cycle so no transfer can slip
  // through while the job is being aborted.
  logic in_ready_w;
  logic out_valid_w;

  assign in_ready_w   = in_ready_c  & ~rst;
  assign out_valid_w  = out_valid_c & ~rst;

  assign st.in_ready  = in_ready_w;
  assign st.out_valid = out_valid_w;
  assign st.out_last  = last_c & out_valid_w;
  assign st.cout      = out_valid_w ? cout_c : '0;

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      sout_q  <= '0;
      pad_q   <= '0;
      cpad_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sout_q  <= sout_d;
      pad_q   <= pad_d;
      cpad_q  <= cpad_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // String buffer: not reset, only ever read at indices written this job.
  always_ff @(posedge clk) begin
    if (in_ready_w && st.in_valid) begin
      mem_q[idx_q[AW-1:0]] <= st.cin;
    end
  end

endmodule

// File: tb/tb_pad_stream.sv
// Self-checking bench for pad_stream: directed jobs plus randomized jobs against a reference model.
// Latency: checks done timing relative to the final handshake of each job.
// Backpressure: exercises always-ready, 1/0/0 stall and random out_ready patterns.
module tb_pad_stream;

  localparam int SMAX = 8;
  localparam int CW   = 8;
  localparam int LW   = $clog2(SMAX+1);
  localparam int DW   = $clog2(2*SMAX+1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [LW-1:0] strlen;
  logic [DW-1:0] desired;
  logic [CW-1:0] cpad;
  logic          mode;
  logic          busy;
  logic          done;

  pad_stream_if #(.CHAR_W(CW)) bus ();

  pad_stream #(.STR_LEN_MAX(SMAX), .CHAR_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .strlen_i  (strlen),
    .desired_i (desired),
    .cpad_i    (cpad),
    .mode_i    (mode),
    .st        (bus),
    .busy_o    (busy),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] job_ch [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job. pat: 0 = always ready / always valid, 1 = out_ready 1,0,0 repeating,
  // 2 = random valid/ready. abort_at >= 0 asserts rst while beat abort_at is presented.
  task automatic run_job(input logic md, input logic [7:0] pc, input int des, input int sl,
                         input int pat, input int abort_at);
    logic [7:0] exp_q[$];
    int L, S, P, ptr, k, cs, end_c, done_c, j, c;
    logic stalled, fin;
    logic [7:0] prev_c;
    logic prev_l;

    // Reference model: expected beat sequence straight from the padding rules.
    L = (sl > SMAX) ? SMAX : sl;
    S = L;
`ifdef PAD_STREAM_TRUNC_EN
    if (des < L) S = des;
`endif
    P = (des > L) ? des - L : 0;
    exp_q = {};
    if (md) begin
      for (int i = 0; i < S; i++) exp_q.push_back(job_ch[i]);
      for (int i = 0; i < P; i++) exp_q.push_back(pc);
    end else begin
      for (int i = 0; i < P; i++) exp_q.push_back(pc);
      for (int i = 0; i < S; i++) exp_q.push_back(job_ch[i]);
    end

    @(posedge clk); #1;
    start         = 1'b1;
    strlen        = LW'(sl);
    desired       = DW'(des);
    cpad          = pc;
    mode          = md;
    bus.in_valid  = 1'b1;      // ignored while idle
    bus.cin       = 8'hEE;
    bus.out_ready = 1'b0;
    @(negedge clk);
    cs      = cyc;
    end_c   = cs;
    ptr     = 0;
    k       = 0;
    done_c  = -1;
    stalled = 1'b0;
    fin     = 1'b0;
    j       = 0;
    prev_c  = '0;
    prev_l  = 1'b0;

    for (int i = 0; i < 400 && !fin; i++) begin
      @(posedge clk); #1;
      if (abort_at >= 0 && k == abort_at && bus.out_valid) begin
        start        = 1'b0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy",      32'(busy),          32'd0);
        check("abort_in_ready",  32'(bus.in_ready),  32'd0);
        check("abort_out_last",  32'(bus.out_last),  32'd0);
        check("abort_cout",      32'(bus.cout),      32'd0);
        check("abort_done",      32'(done),          32'd0);
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", 32'(done), 32'd0);
        end
        bus.out_ready = 1'b0;
        return;
      end
      // Garbage start while busy must be ignored.
      if (busy) begin
        start   = 1'($urandom);
        strlen  = LW'($urandom);
        desired = DW'($urandom);
        cpad    = 8'($urandom);
        mode    = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (ptr < L) begin
        bus.in_valid = (pat == 0) ? 1'b1 : 1'($urandom);
        bus.cin      = job_ch[ptr];
      end else begin
        bus.in_valid = 1'($urandom);
        bus.cin      = 8'($urandom);
      end
      case (pat)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (j % 3 == 0);
        default: bus.out_ready = 1'($urandom);
      endcase
      if (bus.out_valid) j++;

      @(negedge clk);
      c = cyc;
      if (bus.in_valid && bus.in_ready) begin
        ptr++;
        end_c = c;
      end
      if (stalled) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_cout",  32'(bus.cout),      32'(prev_c));
        check("hold_last",  32'(bus.out_last),  32'(prev_l));
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (k < exp_q.size()) begin
            check("cout", 32'(bus.cout), 32'(exp_q[k]));
            check("out_last", 32'(bus.out_last), 32'(k == exp_q.size() - 1));
          end else begin
            check("extra_beat", 32'(k + 1), 32'(exp_q.size()));
          end
          k++;
          end_c   = c;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev_c  = bus.cout;
          prev_l  = bus.out_last;
        end
      end else if (!stalled) begin
        check("cout_idle", 32'(bus.cout), 32'd0);
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        fin    = 1'b1;
        done_c = c;
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end

    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("done_seen",  32'(fin),   32'd1);
    check("beat_count", 32'(k),     32'(exp_q.size()));
    check("read_count", 32'(ptr),   32'(L));
    check("done_cycle", 32'(done_c), 32'(end_c + 1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic load_foo();
    for (int i = 0; i < 16; i++) job_ch[i] = 8'h00;
    job_ch[0] = 8'h66;  // f
    job_ch[1] = 8'h6f;  // o
    job_ch[2] = 8'h6f;  // o
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    strlen        = '0;
    desired       = '0;
    cpad          = '0;
    mode          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.cin       = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Left pad "!!foo", right pad "foo!!", stalled left pad.
    load_foo();
    run_job(1'b0, 8'h21, 5, 3, 0, -1);
    run_job(1'b1, 8'h21, 5, 3, 0, -1);
    run_job(1'b0, 8'h21, 5, 3, 1, -1);
    // Desired shorter than the string.
    run_job(1'b0, 8'h21, 0, 3, 0, -1);
    run_job(1'b1, 8'h21, 2, 3, 0, -1);
    // Empty string: no beats, then pad only.
    run_job(1'b0, 8'h21, 0, 0, 0, -1);
    run_job(1'b0, 8'h21, 2, 0, 0, -1);
    run_job(1'b1, 8'h21, 2, 0, 0, -1);
    // Abort during the second pad beat, then a fresh job.
    run_job(1'b0, 8'h21, 5, 3, 0, 1);
    run_job(1'b0, 8'h21, 5, 3, 0, -1);
    // Full-length string with maximum pad, and an over-long strlen that clamps.
    for (int i = 0; i < 16; i++) job_ch[i] = 8'($urandom);
    run_job(1'b1, 8'h2a, 16, 8, 1, -1);
    run_job(1'b0, 8'h2a, 10, 12, 2, -1);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) job_ch[i] = 8'($urandom);
      run_job(1'($urandom), 8'($urandom), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 11)), int'($urandom_range(0, 2)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
